// File: rtl/rr_mux_reg_pkg.sv
// Shared arbitration-mode encodings and width helper for the mux utilities.
package rr_mux_reg_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Ceiling log2, never below 1 so a one-bit index always exists.
    function automatic int clog2_f(input int value);
        int result;
        result = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = int'(i) + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_mux_reg_arbiter.sv
// Combinational arbiter: one-hot grant and encoded index, rotating or fixed priority.
module rr_arbiter
    import rr_mux_reg_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int FIXED_PRIORITY = MODE_RR,
    parameter int SEL_WIDTH      = clog2_f(CHANNELS)
) (
    input  logic [CHANNELS-1:0]  i_req,
    input  logic [SEL_WIDTH-1:0] i_ptr,
    output logic [CHANNELS-1:0]  o_grant,
    output logic [SEL_WIDTH-1:0] o_idx,
    output logic                 o_any
);

    localparam int CW = SEL_WIDTH + 1;
    localparam arb_mode_e ARB_MODE = (FIXED_PRIORITY == MODE_FIXED) ? ARB_FIXED : ARB_RR;

    logic [CW-1:0] w_start;
    logic [CW-1:0] w_ch;

    // The extra bit lets start+offset exceed CHANNELS before the single wrap subtract,
    // so non-power-of-two channel counts never produce an out-of-range index.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_ch    = '0;
        w_start = (ARB_MODE == ARB_FIXED) ? '0 : {1'b0, i_ptr};
        for (int unsigned off = 0; off < CHANNELS; off++) begin
            w_ch = w_start + CW'(off);
            if (w_ch >= CW'(CHANNELS)) begin
                w_ch = w_ch - CW'(CHANNELS);
            end
            if (!o_any && i_req[w_ch[SEL_WIDTH-1:0]]) begin
                o_any                       = 1'b1;
                o_grant[w_ch[SEL_WIDTH-1:0]] = 1'b1;
                o_idx                       = w_ch[SEL_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel valid/ready arbitrated mux with a single registered output stage.
module rr_mux_reg
    import rr_mux_reg_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 32,
    parameter int CHANNELS       = 4,
    parameter int SEL_WIDTH      = clog2_f(CHANNELS),
    parameter int FIXED_PRIORITY = MODE_RR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CHANNELS-1:0]               in_valid,
    input  logic [CHANNELS*OPERAND_WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]               in_ready,
    output logic                              out_valid,
    output logic [OPERAND_WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]              out_sel,
    input  logic                              out_ready
);

    localparam arb_mode_e ARB_MODE = (FIXED_PRIORITY == MODE_FIXED) ? ARB_FIXED : ARB_RR;

    logic [CHANNELS-1:0]      w_grant;
    logic [SEL_WIDTH-1:0]     w_idx;
    logic                     w_any;
    logic                     w_load;
    logic [SEL_WIDTH-1:0]     w_ptr_next;
    logic [OPERAND_WIDTH-1:0] w_sel_data;

    logic [SEL_WIDTH-1:0]     r_ptr;
    logic                     r_out_valid;
    logic [OPERAND_WIDTH-1:0] r_out_data;
    logic [SEL_WIDTH-1:0]     r_out_sel;

    rr_arbiter #(
        .CHANNELS       (CHANNELS),
        .FIXED_PRIORITY (FIXED_PRIORITY),
        .SEL_WIDTH      (SEL_WIDTH)
    ) u_arbiter (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_load     = !r_out_valid || out_ready;
        in_ready   = w_load ? w_grant : '0;
        w_ptr_next = (w_idx == SEL_WIDTH'(CHANNELS - 1)) ? '0 : w_idx + 1'b1;
        w_sel_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_idx == SEL_WIDTH'(i)) begin
                w_sel_data = in_data[i*OPERAND_WIDTH +: OPERAND_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_sel_data;
                r_out_sel  <= w_idx;
                if (ARB_MODE == ARB_RR) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg: vector table, reference model and beat scoreboard.
module tb_rr_mux_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    logic [3:0]   fp_in_ready;
    logic         fp_out_valid;
    logic [31:0]  fp_out_data;
    logic [1:0]   fp_out_sel;

    always #5 clk = ~clk;

    rr_mux_reg #(
        .OPERAND_WIDTH  (32),
        .CHANNELS       (4),
        .FIXED_PRIORITY (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    rr_mux_reg #(
        .OPERAND_WIDTH  (32),
        .CHANNELS       (4),
        .FIXED_PRIORITY (1)
    ) dut_fp (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (fp_in_ready),
        .out_valid (fp_out_valid),
        .out_data  (fp_out_data),
        .out_sel   (fp_out_sel),
        .out_ready (out_ready)
    );

    typedef struct packed {
        logic       rst;
        logic [3:0] iv;
        logic       ordy;
        logic       chk;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_sel;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;

    vec_t  tbl [22];
    beat_t q [$];

    int n_chk = 0;
    int n_err = 0;

    logic        m_known = 1'b0;
    logic        m_ov;
    logic [31:0] m_od;
    logic [1:0]  m_os;
    int          m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // First requester found scanning from ptr upward with wrap-around.
    function automatic logic [3:0] m_grant(input logic [3:0] iv, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (iv[(ptr + k) % 4]) return 4'b0001 << ((ptr + k) % 4);
        end
        return 4'b0000;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int k = 0; k < 4; k++) begin
            if (g[k]) return k;
        end
        return 0;
    endfunction

    task automatic drive(input logic r, input logic [3:0] iv, input logic ordy);
        rst       = r;
        in_valid  = iv;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) begin
            in_data[i*32 +: 32] = $urandom();
        end
    endtask

    // Checks at the falling edge, with inputs stable and registers settled.
    task automatic settle();
        logic [3:0] g;
        beat_t      b;
        @(negedge clk);
        if (m_known) begin
            g = (!m_ov || out_ready) ? m_grant(in_valid, m_ptr) : 4'b0000;
            chk("in_ready", 32'(in_ready), 32'(g));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("out_data", out_data, m_od);
            chk("out_sel", 32'(out_sel), 32'(m_os));
            if (out_valid === 1'b1 && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_underflow: got output beat expected none at %0t", $time);
                end else begin
                    b = q.pop_front();
                    chk("sb_data", out_data, b.d);
                    chk("sb_sel", 32'(out_sel), 32'(b.s));
                end
            end
        end
    endtask

    task automatic tick();
        logic         r;
        logic         o;
        logic [3:0]   v;
        logic [127:0] d;
        logic [3:0]   g;
        int           c;
        r = rst;
        o = out_ready;
        v = in_valid;
        d = in_data;
        @(posedge clk);
        if (r) begin
            m_ov    = 1'b0;
            m_od    = '0;
            m_os    = '0;
            m_ptr   = 0;
            m_known = 1'b1;
            q.delete();
        end else if (m_known && (!m_ov || o)) begin
            g = m_grant(v, m_ptr);
            if (g != 4'b0000) begin
                c     = onehot_idx(g);
                m_ov  = 1'b1;
                m_od  = d[c*32 +: 32];
                m_os  = 2'(c);
                m_ptr = (c + 1) % 4;
                q.push_back('{m_od, m_os});
            end else begin
                m_ov = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] saved;

        //            rst   iv      ordy  chk   rdy     ov    sel
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[6]  = '{1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd2};
        tbl[8]  = '{1'b0, 4'b0101, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 4'b0101, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd2};
        tbl[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[11] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[12] = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[13] = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1};
        tbl[14] = '{1'b0, 4'b0010, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1};
        tbl[15] = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1};
        tbl[16] = '{1'b0, 4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[17] = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[18] = '{1'b1, 4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[19] = '{1'b0, 4'b1111, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[21] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};

        drive(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].ordy);
            settle();
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
                chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
                chk($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].exp_sel));
            end
            tick();
        end

        // Backpressure: load 0xDEADBEEF, stall 3 cycles with channel 1 waiting.
        drive(1'b0, 4'b0001, 1'b0);
        in_data[31:0] = 32'hDEADBEEF;
        settle();
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0010, 1'b0);
            in_data[63:32] = 32'hCAFEF00D;
            settle();
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_hold_data", out_data, 32'hDEADBEEF);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            tick();
        end
        drive(1'b0, 4'b0010, 1'b1);
        in_data[63:32] = 32'hCAFEF00D;
        settle();
        chk("bp_release_ready", 32'(in_ready), 32'h2);
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        settle();
        chk("bp_new_data", out_data, 32'hCAFEF00D);
        chk("bp_new_sel", 32'(out_sel), 32'h1);
        tick();

        // Bubble: single beat on channel 3, then idle.
        drive(1'b0, 4'b1000, 1'b1);
        in_data[127:96] = 32'h12345678;
        settle();
        chk("bub_in_ready", 32'(in_ready), 32'h8);
        tick();
        drive(1'b0, 4'b0000, 1'b1);
        settle();
        chk("bub_valid", 32'(out_valid), 32'h1);
        chk("bub_sel", 32'(out_sel), 32'h3);
        chk("bub_data", out_data, 32'h12345678);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 4'b0000, 1'b1);
            settle();
            chk("bub_idle_valid", 32'(out_valid), 32'h0);
            chk("bub_idle_data", out_data, 32'h12345678);
            tick();
        end

        // Fixed priority instance: channel 1 always beats channel 3.
        saved = '0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'b1010, 1'b1);
            settle();
            chk("fp_in_ready", 32'(fp_in_ready), 32'h2);
            if (i > 0) begin
                chk("fp_out_valid", 32'(fp_out_valid), 32'h1);
                chk("fp_out_sel", 32'(fp_out_sel), 32'h1);
                chk("fp_out_data", fp_out_data, saved);
            end
            saved = in_data[63:32];
            tick();
        end

        // Random traffic against the model and scoreboard.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-channel arbitrated multiplexer: the sequential generalisation of the team's fixed 2/4-way combinational muxes.
- Selects one of CHANNELS valid/ready sources per cycle, either round-robin or fixed priority, and registers the winner into a single output stage.
- Used where several producers share one consumer, e.g. instruction/data requesters sharing a memory port or multiple writeback sources.

Parameters:
OPERAND_WIDTH, 32, data width per channel
CHANNELS, 4, number of input channels (2..16)
SEL_WIDTH, $clog2(CHANNELS), width of the channel index
FIXED_PRIORITY, 0, 0 = round-robin arbitration; 1 = lowest index always wins

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  CHANNELS  per-channel request; bit i belongs to channel i
in_data  input  CHANNELS*OPERAND_WIDTH  channel i occupies bits [i*OPERAND_WIDTH +: OPERAND_WIDTH]
in_ready  output  CHANNELS  per-channel accept; at most one bit high per cycle
out_valid  output  1  output register holds a beat
out_data  output  OPERAND_WIDTH  registered data of the winning channel
out_sel  output  SEL_WIDTH  index of the channel that produced out_data
out_ready  input  1  consumer accepts the current beat

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. Reset has priority over every other event, including a transfer in the same cycle.
- Transfer rules: a beat transfers on an edge where valid&&ready. Inputs transfer on in_valid[i]&&in_ready[i]; output transfers on out_valid&&out_ready.
- Stage enable: load = !out_valid || out_ready. The output register accepts new data when empty or draining in the same cycle, so full throughput is 1 beat/cycle.
- Grant (combinational from in_valid and ptr only, independent of out_ready):
  - FIXED_PRIORITY=1: grant goes to the lowest i with in_valid[i].
  - FIXED_PRIORITY=0: grant goes to the first i with in_valid[i], searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1 (wrap-around).
- in_ready[i] = grant[i] && load. No in_ready is asserted when no in_valid is high. in_ready depends on in_valid; there is no combinational path from in_data.
- On load with any grant: out_valid<=1, out_data<=in_data of the granted channel, out_sel<=granted index. Round-robin mode also sets ptr<=granted index+1, wrapping CHANNELS-1 to 0.
- On load with no grant: out_valid<=0. out_data and out_sel hold their previous values.
- When load=0 (out_valid=1, out_ready=0): out_valid, out_data, out_sel and ptr all hold. All in_ready are 0. Output data stays stable while stalled.
- Latency: 1 cycle from input transfer to out_valid.
- Pointer behaviour:
  - ptr changes only on an actual input transfer, never on requests that are stalled or not granted.
  - ptr is unused when FIXED_PRIORITY=1 and may be held at 0.
- Simultaneous output drain and new input: both occur on the same edge. The new beat replaces the drained one with no bubble.
- Producers may deassert in_valid before transfer; the arbiter re-evaluates every cycle with no grant lock.
- CHANNELS not a power of two: grant logic never selects an index >= CHANNELS.

Decomposition:
- Shared package/include: the FIXED_PRIORITY mode encodings (RR=0, FIXED=1) and a clog2 helper constant function, shared with the existing mux utilities.
- One natural sub-module: rr_arbiter (CHANNELS, FIXED_PRIORITY).
  - Inputs: req, ptr. Output: one-hot grant plus encoded index; purely combinational.
  - rr_mux_reg wraps it with the pointer register, the data select and the output stage.

Test Plan:
- Reset mid-stream: out_valid=1, out_sel=2, rst=1 for one cycle -> next cycle out_valid=0, out_data=0, out_sel=0, ptr=0, all in_ready=0.
- Round-robin fairness: CHANNELS=4, in_valid=4'b1111 constant, out_ready=1 -> out_sel sequence 0,1,2,3,0,... with out_valid=1 every cycle after the first.
- Wrap-around and skipping: ptr=3, in_valid=4'b0101 -> channel 0 granted; next cycle channel 2 granted; then channel 0.
- Backpressure: out_valid=1, out_data=0xDEADBEEF, out_ready=0 for 3 cycles, in_valid=4'b0010 -> in_ready=0, out_data stays 0xDEADBEEF, ptr unchanged. On out_ready=1: channel 1 granted, its data appears on the next cycle.
- Fixed priority: FIXED_PRIORITY=1, in_valid=4'b1010 held, out_ready=1 -> out_sel=1 every cycle and channel 3 is never granted.
- Bubble/idle: a single beat 0x12345678 on channel 3, then in_valid=0, out_ready=1 -> out_valid high for exactly 1 cycle with out_sel=3, then out_valid=0 with out_data held.
